// File: rtl/lsu.sv
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit between execute and the DCCM. Handles ALU
//            passthrough, sign/zero-extending loads, word stores and
//            read-modify-write byte/halfword stores.
// Config   : LSU_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses
//            are dropped and flagged on misalign_o; otherwise the low
//            address bits are cleared and the access proceeds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        flush_i,
  output logic        dccm_rd_en,
  output logic [31:0] dccm_rd_addr,
  input  logic [31:0] dccm_rd_data,
  output logic        dccm_wr_en,
  output logic [31:0] dccm_wr_addr,
  output logic [31:0] dccm_wr_data,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [29:0] r_addr;     // word address of the accepted op
  logic [1:0]  r_off;      // effective byte offset within the word
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [15:0] r_data;     // only the low half is needed for SB/SH merges
  logic        r_misalign;

  // Pick the byte or halfword out of a read word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   return {{24{b[7] & ~f3[2]}}, b};
      2'b01:   return {{16{h[15] & ~f3[2]}}, h};
      default: return word;
    endcase
  endfunction

  // Overlay a byte or halfword onto the previously read word.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [15:0] d,
                                              input logic [1:0]  off,
                                              input logic        is_half);
    logic [31:0] w;
    w = old_word;
    if (is_half) begin
      if (off[1]) w[31:16] = d;
      else        w[15:0]  = d;
    end else begin
      w[{off, 3'b000} +: 8] = d[7:0];
    end
    return w;
  endfunction

  logic        w_accept;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_half;
  logic        w_word;
  logic        w_trap;
  logic [1:0]  w_off;
  logic        w_do_load;
  logic        w_do_sw;
  logic        w_do_rmw;
  logic [31:0] w_word_addr;

  assign ready_o     = (r_state == IDLE);
  assign w_accept    = valid_i && ready_o;
  // Both class bits high is illegal and falls back to passthrough.
  assign w_is_load   = is_load_i && !is_store_i;
  assign w_is_store  = is_store_i && !is_load_i;
  assign w_half      = (funct3_i[1:0] == 2'b01);
  assign w_word      = funct3_i[1];
  assign w_word_addr = {mem_addr_i[31:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (w_half && mem_addr_i[0]) || (w_word && (mem_addr_i[1:0] != 2'b00));
  assign w_trap     = w_accept && (w_is_load || w_is_store) && w_misalign;
`else
  assign w_trap     = 1'b0;
`endif

  // Offending low bits are cleared so an untrapped misaligned access still lands.
  assign w_off     = w_word ? 2'b00 : (w_half ? {mem_addr_i[1], 1'b0} : mem_addr_i[1:0]);
  assign w_do_load = w_accept && !w_trap && w_is_load;
  assign w_do_sw   = w_accept && !w_trap && w_is_store && w_word;
  assign w_do_rmw  = w_accept && !w_trap && w_is_store && !w_word;

  // DCCM strobes: issue in the accept cycle, or write back the merged word in RMW_WAIT.
  always_comb begin
    dccm_rd_en   = rst_n && (w_do_load || w_do_rmw);
    dccm_rd_addr = w_word_addr;
    dccm_wr_en   = rst_n && w_do_sw;
    dccm_wr_addr = w_word_addr;
    dccm_wr_data = mem_data_i;
    if (r_state == RMW_WAIT) begin
      dccm_wr_en   = rst_n;
      dccm_wr_addr = {r_addr, 2'b00};
      dccm_wr_data = store_merge(dccm_rd_data, r_data, r_off, r_funct3[0]);
    end
  end

  // Control FSM with latched op fields and registered writeback/misalign outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_off      <= '0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_data     <= '0;
      r_misalign <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      r_misalign <= w_trap;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr   <= mem_addr_i[31:2];
            r_off    <= w_off;
            r_funct3 <= funct3_i;
            r_rd     <= rd_i;
            r_data   <= mem_data_i[15:0];
            if (!(w_is_load || w_is_store)) begin
              wb_valid_o <= (rd_i != 5'd0);
              wb_rd_o    <= rd_i;
              wb_data_o  <= rd_data_i;
            end else if (w_do_load) begin
              r_state <= LOAD_WAIT;
            end else if (w_do_rmw) begin
              r_state <= RMW_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          wb_valid_o <= !flush_i && (r_rd != 5'd0);
          wb_rd_o    <= r_rd;
          wb_data_o  <= load_extract(dccm_rd_data, r_off, r_funct3);
          r_state    <= IDLE;
        end
        RMW_WAIT: begin
          // The merged write goes out this cycle regardless of flush_i.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign misalign_o = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu: directed corner cases followed by
//            random ops, compared against a transaction-level reference
//            model with its own copy of the DCCM contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] rd_data_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        flush_i;
  logic        dccm_rd_en;
  logic [31:0] dccm_rd_addr;
  logic [31:0] dccm_rd_data;
  logic        dccm_wr_en;
  logic [31:0] dccm_wr_addr;
  logic [31:0] dccm_wr_data;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .rd_i(rd_i), .rd_data_i(rd_data_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .flush_i(flush_i),
    .dccm_rd_en(dccm_rd_en), .dccm_rd_addr(dccm_rd_addr), .dccm_rd_data(dccm_rd_data),
    .dccm_wr_en(dccm_wr_en), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o)
  );

  // DCCM model: 256 words indexed by addr[9:2], one-cycle read latency, plus a backdoor port.
  logic [31:0] mem [256];
  logic [31:0] rd_q;
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_val;
  always @(posedge clk) begin
    if (bd_we)           mem[bd_idx] <= bd_val;
    else if (dccm_wr_en) mem[dccm_wr_addr[9:2]] <= dccm_wr_data;
    if (dccm_rd_en)      rd_q <= mem[dccm_rd_addr[9:2]];
  end
  assign dccm_rd_data = rd_q;

  // Reference view of memory, updated only by the model.
  logic [31:0] ref_mem [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Apply one op and check all its visible effects over the following cycles.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] rdd,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic flush, input logic rst_mid);
    logic        is_ld, is_st, mis, trap, busy, pass;
    int          sz;
    logic [1:0]  off;
    logic [31:0] old, mask, exp_w, sh, val;
    is_ld = ld & ~st;
    is_st = st & ~ld;
    pass  = !(is_ld || is_st);
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis   = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = (is_ld || is_st) && mis;
`else
    trap  = 1'b0;
`endif
    off   = (sz == 4) ? 2'b00 : (sz == 2) ? (addr[1:0] & 2'b10) : addr[1:0];
    busy  = !trap && (is_ld || (is_st && sz != 4));
    old   = ref_mem[addr[9:2]];
    sh    = 32'(off) * 8;

    // Cycle N: present the op
    @(negedge clk);
    valid_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3;
    rd_i = rd; rd_data_i = rdd; mem_addr_i = addr; mem_data_i = data;
    flush_i = 1'($urandom);
    #1;
    check("ready_N", 32'(ready_o), 32'd1);
    check("wb_idle", 32'(wb_valid_o), 32'd0);
    check("mis_idle", 32'(misalign_o), 32'd0);
    check("rd_en_N", 32'(dccm_rd_en), 32'(busy));
    check("wr_en_N", 32'(dccm_wr_en), 32'(!trap && is_st && sz == 4));
    if (busy) check("rd_addr_N", dccm_rd_addr, addr & 32'hFFFF_FFFC);
    if (!trap && is_st && sz == 4) begin
      check("wr_addr_N", dccm_wr_addr, addr & 32'hFFFF_FFFC);
      check("wr_data_N", dccm_wr_data, data);
    end

    // Cycle N+1: scramble inputs; they must be ignored
    @(negedge clk);
    valid_i = busy ? 1'($urandom) : 1'b0;
    is_load_i = 1'($urandom); is_store_i = 1'($urandom); funct3_i = 3'($urandom);
    rd_i = 5'($urandom); rd_data_i = $urandom; mem_addr_i = $urandom; mem_data_i = $urandom;
    flush_i = is_ld ? flush : 1'($urandom);
    if (rst_mid) rst_n = 1'b0;
    #1;
    if (!trap && is_st && sz == 4) ref_mem[addr[9:2]] = data;
    if (rst_mid) begin
      check("rst_wr_en", 32'(dccm_wr_en), 32'd0);
      check("rst_rd_en", 32'(dccm_rd_en), 32'd0);
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_wb", 32'(wb_valid_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; valid_i = 1'b0;
      #1;
      check("rst_rel_ready", 32'(ready_o), 32'd1);
      check("rst_rel_wb", 32'(wb_valid_o), 32'd0);
      return;
    end
    check("ready_N1", 32'(ready_o), 32'(!busy));
    check("mis_N1", 32'(misalign_o), 32'(trap));
    check("rd_en_N1", 32'(dccm_rd_en), 32'd0);
    if (pass) begin
      check("wb_valid_pass", 32'(wb_valid_o), 32'(rd != 5'd0));
      if (rd != 5'd0) begin
        check("wb_rd_pass", 32'(wb_rd_o), 32'(rd));
        check("wb_data_pass", wb_data_o, rdd);
      end
    end else begin
      check("wb_valid_N1", 32'(wb_valid_o), 32'd0);
    end
    if (busy && is_st) begin
      mask  = ((sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
      exp_w = (old & ~mask) | ((data << sh) & mask);
      check("rmw_wr_en", 32'(dccm_wr_en), 32'd1);
      check("rmw_wr_addr", dccm_wr_addr, addr & 32'hFFFF_FFFC);
      check("rmw_wr_data", dccm_wr_data, exp_w);
      ref_mem[addr[9:2]] = exp_w;
    end else begin
      check("wr_en_N1", 32'(dccm_wr_en), 32'd0);
    end

    // Cycle N+2: load writeback
    if (busy && is_ld) begin
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      val = old >> sh;
      if (sz == 1) begin
        val = val & 32'hFF;
        if (!f3[2] && val[7]) val = val | 32'hFFFF_FF00;
      end else if (sz == 2) begin
        val = val & 32'hFFFF;
        if (!f3[2] && val[15]) val = val | 32'hFFFF_0000;
      end else begin
        val = old;
      end
      check("wb_valid_ld", 32'(wb_valid_o), 32'(rd != 5'd0 && !flush));
      if (rd != 5'd0 && !flush) begin
        check("wb_rd_ld", 32'(wb_rd_o), 32'(rd));
        check("wb_data_ld", wb_data_o, val);
      end
      check("ready_N2", 32'(ready_o), 32'd1);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    logic       ld, st, fl, rm;
    logic [2:0] f3;
    logic [4:0] rd;
    int         cls, k;

    rst_n = 1'b0; valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0;
    funct3_i = 3'b010; rd_i = 5'd3; rd_data_i = '0; mem_addr_i = 32'h40;
    mem_data_i = '0; flush_i = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_val = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rd_en", 32'(dccm_rd_en), 32'd0);
    check("reset_wr_en", 32'(dccm_wr_en), 32'd0);
    check("reset_wb_valid", 32'(wb_valid_o), 32'd0);
    check("reset_wb_rd", 32'(wb_rd_o), 32'd0);
    check("reset_wb_data", wb_data_o, 32'd0);
    check("reset_misalign", 32'(misalign_o), 32'd0);
    check("reset_ready", 32'(ready_o), 32'd1);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);

    // Directed corner cases
    do_op(1'b0, 1'b0, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0);
    poke(8'h40, 32'h80FF_0000);
    do_op(1'b1, 1'b0, 3'b000, 5'd7, 32'h0, 32'h103, 32'h0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 3'b100, 5'd7, 32'h0, 32'h103, 32'h0, 1'b0, 1'b0);
    poke(8'h80, 32'h1111_2222);
    do_op(1'b0, 1'b1, 3'b001, 5'd0, 32'h0, 32'h202, 32'hABCD, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 3'b010, 5'd8, 32'h0, 32'h200, 32'h0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 3'b010, 5'd8, 32'h0, 32'h200, 32'h0, 1'b1, 1'b0);
    do_op(1'b1, 1'b0, 3'b010, 5'd9, 32'h0, 32'h301, 32'h0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 3'b001, 5'd0, 32'h0, 32'h206, 32'h5555, 1'b0, 1'b1);
    do_op(1'b1, 1'b0, 3'b010, 5'd4, 32'h0, 32'h204, 32'h0, 1'b0, 1'b1);
    do_op(1'b1, 1'b1, 3'b010, 5'd6, 32'hCAFE_F00D, 32'h301, 32'h0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 3'b000, 5'd0, 32'h0, 32'h101, 32'h0, 1'b0, 1'b0);

    // Random ops
    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(0, 3);
      ld  = (cls == 1) || (cls == 3);
      st  = (cls == 2) || (cls == 3);
      if (st && !ld) f3 = 3'($urandom_range(0, 2));
      else begin
        k  = $urandom_range(0, 4);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      fl = ($urandom_range(0, 3) == 0);
      rm = ($urandom_range(0, 31) == 0);
      do_op(ld, st, f3, rd, $urandom, $urandom, $urandom, fl, rm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 valid_i  input  1  exe-to-mem op valid.
REQ-004 ready_o  output  1  lsu can accept an op this cycle.
REQ-005 is_load_i / is_store_i  input  1 each  op class; both low means ALU passthrough; both high is illegal and treated as passthrough.
REQ-006 funct3_i  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 rd_i  input  5  destination register.
REQ-008 rd_data_i  input  32  ALU result for passthrough ops.
REQ-009 mem_addr_i  input  32  byte address.
REQ-010 mem_data_i  input  32  store data, right-aligned.
REQ-011 flush_i  input  1  kill in-flight load writeback.
REQ-012 dccm_rd_en, dccm_wr_en  output  1 each; dccm_rd_addr, dccm_wr_addr, dccm_wr_data  output  32 each; dccm_rd_data  input  32.
REQ-013 wb_valid_o  output  1; wb_rd_o  output  5; wb_data_o  output  32  registered writeback.
REQ-014 misalign_o  output  1  one-cycle misaligned-access flag (macro-dependent).

Function
REQ-015 The FSM SHALL have states IDLE, LOAD_WAIT, RMW_WAIT; ready_o = (state==IDLE).
REQ-016 An op SHALL be accepted in cycle N when valid_i && ready_o.
REQ-017 DCCM addresses SHALL be word-aligned: {mem_addr_i[31:2],2'b00}; DCCM read data SHALL be valid the cycle after dccm_rd_en.
REQ-018 Passthrough: wb_valid_o=1, wb_rd_o=rd_i, wb_data_o=rd_data_i in cycle N+1; state stays IDLE.
REQ-019 Load: dccm_rd_en=1 combinationally in N; IDLE->LOAD_WAIT; in N+1 the byte/half selected by addr[1:0] SHALL be sign/zero-extended per funct3 and registered; wb_valid_o=1 in N+2; LOAD_WAIT->IDLE.
REQ-020 SW: dccm_wr_en=1 with mem_data_i combinationally in N; no writeback; state stays IDLE.
REQ-021 SB/SH: dccm_rd_en=1 in N; IDLE->RMW_WAIT; in N+1 the read word SHALL be merged with the byte/half at addr[1:0] and written (dccm_wr_en=1, same address); RMW_WAIT->IDLE.
REQ-022 Address, data, funct3 and rd SHALL be latched at acceptance; inputs in later cycles SHALL be ignored.
REQ-023 rd_i==0 SHALL suppress wb_valid_o for loads and passthrough.
REQ-024 flush_i high in LOAD_WAIT SHALL suppress the resulting writeback; flush_i in RMW_WAIT SHALL NOT cancel the write; flush_i in IDLE SHALL have no effect.
REQ-025 dccm_rd_en and dccm_wr_en SHALL never be high in the same cycle.
REQ-026 wb_valid_o and misalign_o SHALL be single-cycle pulses.

Reset
REQ-027 On rst_n low: state=IDLE, wb_valid_o=0, wb_rd_o=0, wb_data_o=0, misalign_o=0; dccm_rd_en and dccm_wr_en SHALL be 0 while rst_n is low.
REQ-028 Reset during LOAD_WAIT or RMW_WAIT SHALL abandon the op with no DCCM write and no writeback.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL do no DCCM access and no writeback, and SHALL pulse misalign_o in N+1.
REQ-030 LSU_MISALIGN_TRAP_EN undefined: misalign_o tied 0; offending low address bits SHALL be cleared (H to addr[1], W to offset 0) and the access performed.

Verification
REQ-031 Passthrough rd=5, rd_data=0x1234 -> wb_valid_o N+1, wb_rd_o=5, wb_data_o=0x1234.
REQ-032 LB addr 0x103, DCCM word 0x80FF_0000 -> rd_addr 0x100 in N, wb_data_o=0xFFFF_FF80 in N+2; LBU -> 0x0000_0080.
REQ-033 SH addr 0x202, data 0xABCD, memory 0x1111_2222 -> read N, write 0xABCD_2222 to 0x200 in N+1, ready_o low in N+1.
REQ-034 LW accepted, flush_i high in N+1 -> no wb_valid_o; next op accepted in N+2.
REQ-035 LW addr 0x301: with macro, misalign_o pulse in N+1 and no DCCM access; without, word read from 0x300 written back in N+2.
REQ-036 rst_n low in RMW_WAIT -> no dccm_wr_en, state IDLE, ready_o=1 after release.
